// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order writeback buffer draining one entry per cycle to the
// register file write port, with two combinational youngest-value forwarding lookups.
module reg_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        WB_VALID,
    output logic                        WB_READY,
    input  logic [ADDR_WIDTH-1:0]       WB_REG,
    input  logic [DATA_WIDTH-1:0]       WB_DATA,
    input  logic                        DRAIN_STALL,
    output logic                        REG_WRITE_ENABLE,
    output logic [ADDR_WIDTH-1:0]       WRITE_REG,
    output logic [DATA_WIDTH-1:0]       WRITE_DATA,
    input  logic [ADDR_WIDTH-1:0]       FWD_REG_A,
    output logic                        FWD_HIT_A,
    output logic [DATA_WIDTH-1:0]       FWD_DATA_A,
    input  logic [ADDR_WIDTH-1:0]       FWD_REG_B,
    output logic                        FWD_HIT_B,
    output logic [DATA_WIDTH-1:0]       FWD_DATA_B,
    output logic [$clog2(DEPTH):0]      COUNT,
    output logic                        EMPTY
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] reg_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  push, pop;

    assign WB_READY = count_q != (PW+1)'(DEPTH);
    // Writes to r0 complete the handshake but never occupy a slot.
    assign push = WB_VALID & WB_READY & |WB_REG;
    assign pop  = |count_q & ~DRAIN_STALL;

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        we_d    = pop;
        wreg_d  = pop ? reg_q[head_q] : wreg_q;
        wdata_d = pop ? data_q[head_q] : wdata_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            reg_q[tail_q]  <= WB_REG;
            data_q[tail_q] <= WB_DATA;
        end
    end

    // Scan oldest to youngest so later matches override; output stage is oldest of all.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] r);
        logic [DATA_WIDTH:0] res;
        logic [PW-1:0]       idx;
        res = (we_q && wreg_q == r) ? {1'b1, wdata_q} : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((PW+1)'(i) < count_q && reg_q[idx] == r) res = {1'b1, data_q[idx]};
        end
        return (r == '0) ? '0 : res;
    endfunction

    assign {FWD_HIT_A, FWD_DATA_A} = lookup(FWD_REG_A);
    assign {FWD_HIT_B, FWD_DATA_B} = lookup(FWD_REG_B);

    assign REG_WRITE_ENABLE = we_q;
    assign WRITE_REG        = wreg_q;
    assign WRITE_DATA       = wdata_q;
    assign COUNT            = count_q;
    assign EMPTY            = count_q == '0 && !we_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed self-checking bench for reg_writeback_queue (DEPTH=4).
module tb_reg_writeback_queue;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        WB_VALID, WB_READY, DRAIN_STALL;
    logic [4:0]  WB_REG, WRITE_REG, FWD_REG_A, FWD_REG_B;
    logic [63:0] WB_DATA, WRITE_DATA, FWD_DATA_A, FWD_DATA_B;
    logic        REG_WRITE_ENABLE, FWD_HIT_A, FWD_HIT_B, EMPTY;
    logic [2:0]  COUNT;
    int          total = 0;
    int          bad = 0;

    reg_writeback_queue #(.DEPTH(4), .DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_REG(WB_REG), .WB_DATA(WB_DATA),
        .DRAIN_STALL(DRAIN_STALL),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE), .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
        .FWD_REG_A(FWD_REG_A), .FWD_HIT_A(FWD_HIT_A), .FWD_DATA_A(FWD_DATA_A),
        .FWD_REG_B(FWD_REG_B), .FWD_HIT_B(FWD_HIT_B), .FWD_DATA_B(FWD_DATA_B),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [63:0] d);
        WB_VALID = 1'b1;
        WB_REG   = r;
        WB_DATA  = d;
        tick();
        WB_VALID = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; WB_VALID = 1'b0; WB_REG = '0; WB_DATA = '0;
        DRAIN_STALL = 1'b0; FWD_REG_A = '0; FWD_REG_B = '0;
        tick(); tick();
        chk("rst_we", REG_WRITE_ENABLE, 0);
        chk("rst_wreg", WRITE_REG, 0);
        chk("rst_wdata", WRITE_DATA, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_ready", WB_READY, 1);
        FWD_REG_A = 5'd3; #1;
        chk("rst_hit_a", FWD_HIT_A, 0);
        #2 RESET_N = 1'b1;

        // single write
        WB_VALID = 1'b1; WB_REG = 5'd3; WB_DATA = 64'h1122334455667788; #1;
        chk("sw_ready", WB_READY, 1);
        chk("sw_fwd_pre_edge", FWD_HIT_A, 0);
        tick(); WB_VALID = 1'b0; #1;
        chk("sw_count1", COUNT, 1);
        chk("sw_we0", REG_WRITE_ENABLE, 0);
        chk("sw_empty0", EMPTY, 0);
        chk("sw_fwd_hit", FWD_HIT_A, 1);
        chk("sw_fwd_data", FWD_DATA_A, 64'h1122334455667788);
        tick();
        chk("sw_we1", REG_WRITE_ENABLE, 1);
        chk("sw_wreg", WRITE_REG, 3);
        chk("sw_wdata", WRITE_DATA, 64'h1122334455667788);
        chk("sw_count0", COUNT, 0);
        chk("sw_fwd_out_hit", FWD_HIT_A, 1);
        tick();
        chk("sw_we_pulse", REG_WRITE_ENABLE, 0);
        chk("sw_empty1", EMPTY, 1);
        chk("sw_wreg_hold", WRITE_REG, 3);
        chk("sw_fwd_gone", FWD_HIT_A, 0);

        // zero-register drop
        WB_VALID = 1'b1; WB_REG = 5'd0; WB_DATA = 64'hDEAD; #1;
        chk("z_ready", WB_READY, 1);
        tick(); WB_VALID = 1'b0;
        chk("z_count", COUNT, 0);
        chk("z_we0", REG_WRITE_ENABLE, 0);
        tick();
        chk("z_we1", REG_WRITE_ENABLE, 0);
        FWD_REG_A = 5'd0; #1;
        chk("z_fwd_hit", FWD_HIT_A, 0);
        chk("z_fwd_data", FWD_DATA_A, 0);

        // full / backpressure
        DRAIN_STALL = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 64'(i));
        chk("full_count", COUNT, 4);
        chk("full_ready", WB_READY, 0);
        WB_VALID = 1'b1; WB_REG = 5'd6; WB_DATA = 64'd6;
        tick();
        chk("full_held", COUNT, 4);
        chk("full_we", REG_WRITE_ENABLE, 0);
        FWD_REG_A = 5'd2; #1;
        chk("full_fwd2", FWD_DATA_A, 2);
        DRAIN_STALL = 1'b0; #1;
        chk("full_ready_nopop", WB_READY, 0);
        tick();
        chk("bp_we1", REG_WRITE_ENABLE, 1);
        chk("bp_reg1", WRITE_REG, 1);
        chk("bp_data1", WRITE_DATA, 1);
        chk("bp_count3", COUNT, 3);
        chk("bp_ready", WB_READY, 1);
        tick(); WB_VALID = 1'b0;
        chk("bp_reg2", WRITE_REG, 2);
        chk("bp_count_pp", COUNT, 3);
        tick();
        chk("bp_reg3", WRITE_REG, 3);
        tick();
        chk("bp_reg4", WRITE_REG, 4);
        chk("bp_data4", WRITE_DATA, 4);
        tick();
        chk("bp_reg6", WRITE_REG, 6);
        chk("bp_we6", REG_WRITE_ENABLE, 1);
        chk("bp_count0", COUNT, 0);
        tick();
        chk("bp_empty", EMPTY, 1);

        // forwarding priority
        DRAIN_STALL = 1'b1; FWD_REG_B = 5'd5; FWD_REG_A = 5'd7;
        push(5'd5, 64'hA);
        push(5'd5, 64'hB);
        chk("fp_hit", FWD_HIT_B, 1);
        chk("fp_young", FWD_DATA_B, 64'hB);
        chk("fp_miss_hit", FWD_HIT_A, 0);
        chk("fp_miss_data", FWD_DATA_A, 0);
        DRAIN_STALL = 1'b0;
        tick();
        chk("fp_out_old", WRITE_DATA, 64'hA);
        chk("fp_still_young", FWD_DATA_B, 64'hB);
        tick();
        chk("fp_out_young", FWD_DATA_B, 64'hB);
        chk("fp_out_hit", FWD_HIT_B, 1);
        tick();
        chk("fp_done", FWD_HIT_B, 0);

        // wrap-around streaming
        for (int i = 0; i < 10; i++) begin
            WB_VALID = 1'b1; WB_REG = 5'(10 + i); WB_DATA = 64'(100 + i);
            tick();
            chk("wr_count", COUNT, 1);
            if (i > 0) begin
                chk("wr_we", REG_WRITE_ENABLE, 1);
                chk("wr_reg", WRITE_REG, 64'(10 + i - 1));
                chk("wr_data", WRITE_DATA, 64'(100 + i - 1));
            end
        end
        WB_VALID = 1'b0;
        tick();
        chk("wr_last_reg", WRITE_REG, 19);
        chk("wr_last_data", WRITE_DATA, 109);
        chk("wr_count0", COUNT, 0);

        // asynchronous reset mid-operation
        DRAIN_STALL = 1'b1;
        push(5'd7, 64'h77);
        push(5'd8, 64'h88);
        push(5'd9, 64'h99);
        chk("ar_count3", COUNT, 3);
        #3 RESET_N = 1'b0;
        #1;
        chk("ar_wreg", WRITE_REG, 0);
        chk("ar_wdata", WRITE_DATA, 0);
        chk("ar_count", COUNT, 0);
        chk("ar_empty", EMPTY, 1);
        DRAIN_STALL = 1'b0; FWD_REG_A = 5'd7; FWD_REG_B = 5'd8;
        #2 RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_write", REG_WRITE_ENABLE, 0);
        end
        chk("ar_count_after", COUNT, 0);
        chk("ar_hit_a", FWD_HIT_A, 0);
        chk("ar_hit_b", FWD_HIT_B, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
